regfile_writeback_queue: RTL

REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

---
 rtl/regfile_writeback_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_queue
// Purpose  : Circular writeback FIFO in front of a register-file write port,
//            with two newest-value forwarding snoop ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_valid,
   output logic                       wb_ready,
   input  logic [4:0]                 wb_addr,
   input  logic [31:0]                wb_data,
   input  logic                       rf_stall,
   output logic                       rf_wr_ena,
   output logic [4:0]                 rf_wr_addr,
   output logic [31:0]                rf_wr_data,
   input  logic [4:0]                 rd_addr0,
   input  logic [4:0]                 rd_addr1,
   output logic                       fwd_hit0,
   output logic                       fwd_hit1,
   output logic [31:0]                fwd_data0,
   output logic [31:0]                fwd_data1,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [4:0]       r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   logic             w_push;
   logic             w_pop;
   logic             w_empty;

   assign w_empty   = (r_count == '0);
   assign wb_ready  = (r_count != C_FULL);
   assign rf_wr_ena = !w_empty && !rf_stall;
   assign w_pop     = rf_wr_ena;
   // Writes to x0 are accepted but never occupy a slot.
   assign w_push    = wb_valid && wb_ready && (wb_addr != 5'd0);

   assign empty      = w_empty;
   assign count      = r_count;
   assign rf_wr_addr = w_empty ? 5'd0  : r_addr[r_head];
   assign rf_wr_data = w_empty ? 32'd0 : r_data[r_head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         // Push and pop never target the same slot: that needs empty or full.
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + AW'(1);
         end
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy is tracked by r_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= wb_addr;
         r_data[r_tail] <= wb_data;
      end
   end

   logic [4:0] w_rd_addr [2];
   assign w_rd_addr[0] = rd_addr0;
   assign w_rd_addr[1] = rd_addr1;

   for (genvar p = 0; p < 2; p++) begin : g_fwd
      logic        w_hit;
      logic [31:0] w_fdata;

      // Walk oldest to newest so the last match found is the newest value.
      always_comb begin
         w_hit   = 1'b0;
         w_fdata = 32'd0;
         for (int k = 0; k < DEPTH; k++) begin
            if (w_rd_addr[p] != 5'd0 &&
                r_valid[r_head + AW'(k)] &&
                r_addr[r_head + AW'(k)] == w_rd_addr[p]) begin
               w_hit   = 1'b1;
               w_fdata = r_data[r_head + AW'(k)];
            end
         end
      end
   end

   assign fwd_hit0  = g_fwd[0].w_hit;
   assign fwd_data0 = g_fwd[0].w_fdata;
   assign fwd_hit1  = g_fwd[1].w_hit;
   assign fwd_data1 = g_fwd[1].w_fdata;

endmodule
`default_nettype wire
